// File: rtl/serial_add_sub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_add_sub                                                           |
// | Digit-serial adder/subtractor, DIGIT bits per clock, LSB first, with a   |
// | start/done handshake and registered carry/borrow.                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cOut,
  output logic             overflow
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(STEPS - 1);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_add_sub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_load;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_c;
  logic             r_mode;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_ovf;

  logic [DIGIT-1:0] w_ad;
  logic [DIGIT-1:0] w_bd;
  logic [DIGIT:0]   w_sum;
  logic [DIGIT:0]   w_dif;
  logic [DIGIT-1:0] w_s;
  logic             w_cn;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_RUN;
          w_load       = 1'b1;
        end
      end
      S_RUN: begin
        if (r_cnt == C_LAST) begin
          w_state_next = S_DONE;
          w_last       = 1'b1;
        end
      end
      S_DONE: begin
        if (start) begin
          w_state_next = S_RUN;
          w_load       = 1'b1;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // One shared DIGIT-wide slice; the extra top bit is carry-out on add and
  // goes high exactly when the subtraction wraps (ad < bd + c).
  assign w_ad  = r_a[DIGIT-1:0];
  assign w_bd  = r_b[DIGIT-1:0];
  assign w_sum = {1'b0, w_ad} + {1'b0, w_bd} + {{DIGIT{1'b0}}, r_c};
  assign w_dif = {1'b0, w_ad} - {1'b0, w_bd} - {{DIGIT{1'b0}}, r_c};
  assign w_s   = r_mode ? w_dif[DIGIT-1:0] : w_sum[DIGIT-1:0];
  assign w_cn  = r_mode ? w_dif[DIGIT] : w_sum[DIGIT];

  assign w_acc_next = WIDTH'({w_s, r_acc} >> DIGIT);

  assign w_ovf = (r_mode ? (r_a_msb ^ r_b_msb) : ~(r_a_msb ^ r_b_msb))
               & (w_acc_next[WIDTH-1] ^ r_a_msb);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_c      <= 1'b0;
      r_mode   <= 1'b0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_load) begin
      r_a     <= a;
      r_b     <= b;
      r_c     <= cIn;
      r_mode  <= mode;
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a   <= r_a >> DIGIT;
      r_b   <= r_b >> DIGIT;
      r_c   <= w_cn;
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_result <= w_acc_next;
        r_cout   <= w_cn;
        r_ovf    <= w_ovf;
      end
    end
  end

  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);
  assign result   = r_result;
  assign cOut     = r_cout;
  assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_serial_add_sub                                                        |
// | Directed and exhaustive bench for serial_add_sub at several DIGIT sizes. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_serial_add_sub;

  localparam int STEPS8 [4] = '{8, 4, 2, 1};
  localparam int STEPS4 [2] = '{4, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic       cin = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;

  logic       busy8 [4];
  logic       done8 [4];
  logic       cout8 [4];
  logic       ovf8  [4];
  logic [7:0] res8  [4];

  logic       start4 = 1'b0;
  logic       mode4 = 1'b0;
  logic       cin4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       busy4 [2];
  logic       done4 [2];
  logic       cout4 [2];
  logic       ovf4  [2];
  logic [3:0] res4  [2];

  int n_pass = 0;
  int n_total = 0;

  int         first_k  [4];
  int         n_done   [4];
  int         busy_cnt [4];
  logic [7:0] res_mid;

  typedef struct {
    logic       m;
    logic [7:0] av;
    logic [7:0] bv;
    logic       ci;
    logic [7:0] r;
    logic       c;
    logic       v;
  } vec_t;
  vec_t vecs [7];

  always #5 clk = ~clk;

  // Instance 0..3: WIDTH 8 with DIGIT 1, 2, 4, 8
  for (genvar gi = 0; gi < 4; gi++) begin : g_dut8
    serial_add_sub #(.WIDTH(8), .DIGIT(1 << gi)) u_dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
      .cIn(cin), .busy(busy8[gi]), .done(done8[gi]), .result(res8[gi]),
      .cOut(cout8[gi]), .overflow(ovf8[gi])
    );
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut4
    serial_add_sub #(.WIDTH(4), .DIGIT(gi + 1)) u_dut (
      .clk(clk), .rst(rst), .start(start4), .mode(mode4), .a(a4), .b(b4),
      .cIn(cin4), .busy(busy4[gi]), .done(done4[gi]), .result(res4[gi]),
      .cOut(cout4[gi]), .overflow(ovf4[gi])
    );
  end

  // Pulses start for one edge, scrambles the inputs, then observes 12 cycles.
  task automatic launch_op(input logic m, input logic [7:0] av, input logic [7:0] bv,
                           input logic ci);
    @(negedge clk);
    mode = m; a = av; b = bv; cin = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mode = ~m; a = ~av; b = ~bv; cin = ~ci;
    for (int d = 0; d < 4; d++) begin
      first_k[d] = -1; n_done[d] = 0; busy_cnt[d] = 0;
    end
    for (int k = 0; k < 12; k++) begin
      for (int d = 0; d < 4; d++) begin
        if (done8[d] === 1'b1) begin
          if (first_k[d] < 0) first_k[d] = k;
          n_done[d]++;
        end
        if (busy8[d] === 1'b1) busy_cnt[d]++;
      end
      if (k == 3) res_mid = res8[0];
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      n_total++;
      if ({busy8[d], done8[d], res8[d], cout8[d], ovf8[d]} !== 12'h000)
        $display("FAIL reset d%0d busy/done/res/c/v got %b %b %h %b %b exp all zero",
                 d, busy8[d], done8[d], res8[d], cout8[d], ovf8[d]);
      else n_pass++;
    end
    rst = 1'b0;
  endtask

  task automatic test_arith(input logic m);
    logic [7:0] prev;
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].m == m) begin
        prev = res8[0];
        launch_op(vecs[i].m, vecs[i].av, vecs[i].bv, vecs[i].ci);
        for (int d = 0; d < 4; d++) begin
          n_total++;
          if (res8[d] !== vecs[i].r)
            $display("FAIL arith v%0d d%0d result got %h exp %h", i, d, res8[d], vecs[i].r);
          else n_pass++;
          n_total++;
          if (cout8[d] !== vecs[i].c)
            $display("FAIL arith v%0d d%0d cOut got %b exp %b", i, d, cout8[d], vecs[i].c);
          else n_pass++;
          n_total++;
          if (ovf8[d] !== vecs[i].v)
            $display("FAIL arith v%0d d%0d overflow got %b exp %b", i, d, ovf8[d], vecs[i].v);
          else n_pass++;
          n_total++;
          if (first_k[d] != STEPS8[d])
            $display("FAIL arith v%0d d%0d latency got %0d exp %0d", i, d, first_k[d], STEPS8[d]);
          else n_pass++;
          n_total++;
          if (n_done[d] != 1)
            $display("FAIL arith v%0d d%0d done pulses got %0d exp 1", i, d, n_done[d]);
          else n_pass++;
          n_total++;
          if (busy_cnt[d] != STEPS8[d])
            $display("FAIL arith v%0d d%0d busy cycles got %0d exp %0d", i, d, busy_cnt[d], STEPS8[d]);
          else n_pass++;
        end
        n_total++;
        if (res_mid !== prev)
          $display("FAIL hold_during_run v%0d result got %h exp %h", i, res_mid, prev);
        else n_pass++;
      end
    end
  endtask

  task automatic test_start_ignored();
    int nd = 0;
    int fk = -1;
    @(negedge clk);
    mode = 1'b0; a = 8'h3C; b = 8'h19; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done8[0] === 1'b1) begin
        nd++;
        if (fk < 0) fk = k;
      end
      if (k == 2) begin
        start = 1'b1; a = 8'h01; b = 8'h01;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    n_total++;
    if (nd != 1) $display("FAIL start_ignored done pulses got %0d exp 1", nd);
    else n_pass++;
    n_total++;
    if (fk != 8) $display("FAIL start_ignored latency got %0d exp 8", fk);
    else n_pass++;
    n_total++;
    if (res8[0] !== 8'h55) $display("FAIL start_ignored result got %h exp 55", res8[0]);
    else n_pass++;
  endtask

  task automatic test_start_held();
    int ks [$];
    @(negedge clk);
    mode = 1'b0; a = 8'h3C; b = 8'h19; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 30; k++) begin
      if (done8[0] === 1'b1) ks.push_back(k);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    n_total++;
    if (ks.size() != 3) $display("FAIL start_held done count got %0d exp 3", ks.size());
    else n_pass++;
    n_total++;
    if (ks.size() < 3 || ks[0] != 8 || ks[1] != 17 || ks[2] != 26)
      $display("FAIL start_held done times got %p exp 8 17 26", ks);
    else n_pass++;
    n_total++;
    if (res8[0] !== 8'h55) $display("FAIL start_held result got %h exp 55", res8[0]);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int nd = 0;
    launch_op(1'b0, 8'h80, 8'hFF, 1'b0);
    n_total++;
    if ({res8[0], cout8[0], ovf8[0]} !== {8'h7F, 1'b1, 1'b1})
      $display("FAIL mid_reset setup got %h %b %b exp 7f 1 1", res8[0], cout8[0], ovf8[0]);
    else n_pass++;
    @(negedge clk);
    mode = 1'b0; a = 8'h3C; b = 8'h19; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (done8[0] === 1'b1) nd++;
      if (k == 4) begin
        n_total++;
        if ({busy8[0], res8[0], cout8[0], ovf8[0]} !== 11'h000)
          $display("FAIL mid_reset outputs got busy %b res %h c %b v %b exp all zero",
                   busy8[0], res8[0], cout8[0], ovf8[0]);
        else n_pass++;
      end
      rst = (k == 3);
      @(negedge clk);
    end
    rst = 1'b0;
    n_total++;
    if (nd != 0) $display("FAIL mid_reset done pulses got %0d exp 0", nd);
    else n_pass++;
  endtask

  task automatic test_exhaustive_w4();
    int   full, sa, sb, sf, fk [2];
    logic [3:0] er;
    logic ec, ev;
    logic [3:0] gr [2];
    logic gc [2], gv [2];
    for (int av = 0; av < 16; av++)
      for (int bv = 0; bv < 16; bv++)
        for (int m = 0; m < 2; m++)
          for (int ci = 0; ci < 2; ci++) begin
            @(negedge clk);
            a4 = 4'(av); b4 = 4'(bv); mode4 = m[0]; cin4 = ci[0]; start4 = 1'b1;
            @(negedge clk);
            start4 = 1'b0;
            fk[0] = -1; fk[1] = -1;
            for (int k = 0; k < 6; k++) begin
              for (int d = 0; d < 2; d++)
                if (done4[d] === 1'b1 && fk[d] < 0) begin
                  fk[d] = k; gr[d] = res4[d]; gc[d] = cout4[d]; gv[d] = ovf4[d];
                end
              @(negedge clk);
            end
            sa = (av >= 8) ? av - 16 : av;
            sb = (bv >= 8) ? bv - 16 : bv;
            if (m == 0) begin
              full = av + bv + ci; sf = sa + sb + ci; ec = (full > 15);
            end else begin
              full = av - bv - ci; sf = sa - sb - ci; ec = (full < 0);
            end
            er = 4'(full);
            ev = (sf > 7) || (sf < -8);
            for (int d = 0; d < 2; d++) begin
              n_total++;
              if (fk[d] != STEPS4[d] || {gr[d], gc[d], gv[d]} !== {er, ec, ev})
                $display("FAIL exhaustive d%0d a=%h b=%h m=%0d c=%0d got lat %0d r %h c %b v %b exp lat %0d r %h c %b v %b",
                         d, av, bv, m, ci, fk[d], gr[d], gc[d], gv[d], STEPS4[d], er, ec, ev);
              else n_pass++;
            end
          end
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'h3C, 8'h19, 1'b0, 8'h55, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    test_reset();
    test_arith(1'b0);
    test_arith(1'b1);
    test_start_ignored();
    test_start_held();
    test_mid_reset();
    test_exhaustive_w4();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_add_sub.md
# serial_add_sub

Parametrised digit-serial adder/subtractor with a start/done handshake. It is the sequential successor to the team's single-bit full adder and full subtractor cells. It consumes two WIDTH-bit operands DIGIT bits per clock, LSB first, and reuses one DIGIT-wide add/subtract slice with a registered carry/borrow. It trades latency for area and sits in the datapath wherever a slow, small arithmetic unit is acceptable.

## Interface

Parameters:
- WIDTH, default 8: operand/result width; must be ≥ 2.
- DIGIT, default 1: bits processed per cycle; WIDTH % DIGIT == 0 (elaboration error otherwise). STEPS = WIDTH/DIGIT.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only when busy == 0.
- mode  in  1  0 = add (a + b + cIn), 1 = subtract (a − b − cIn).
- a  in  WIDTH  operand A (minuend when subtracting).
- b  in  WIDTH  operand B (subtrahend when subtracting).
- cIn  in  1  carry-in (add) or borrow-in (sub).
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse: result/cOut/overflow just updated.
- result  out  WIDTH  sum or difference modulo 2^WIDTH.
- cOut  out  1  carry-out (add) or borrow-out (sub) of the MSB.
- overflow  out  1  two's-complement signed overflow.

## Operation

- States: IDLE, RUN, DONE.
- Reset: state = IDLE, busy = 0, done = 0, result = 0, cOut = 0, overflow = 0, step counter = 0. Reset overrides start and any other activity.
- IDLE/DONE, start = 1: latch a, b, mode, and cIn into internal shift registers and the carry flop; counter = 0; go to RUN. Inputs are ignored after this capture.
- IDLE, start = 0: stay. DONE, start = 0: go to IDLE.
- RUN: each cycle, take the low DIGIT bits ad and bd.
  - Add: {c', s} = ad + bd + c.
  - Sub: s = ad − bd − c (mod 2^DIGIT), c' = 1 when ad < bd + c.
  - Shift s into the result accumulator from the MSB side, shift operands right, update c, increment the counter.
- On the step with counter == STEPS−1, go to DONE and simultaneously load:
  - result = accumulator
  - cOut = final c'
  - overflow:
    - add: (a[W−1] == b[W−1]) && (result[W−1] != a[W−1])
    - sub: (a[W−1] != b[W−1]) && (result[W−1] != a[W−1])
    - Operand values are the latched copies.
- result, cOut, and overflow hold their last completed values through IDLE and the whole of a subsequent RUN. They change only at completion or reset.
- start while busy = 1 is ignored, not queued.
- Mid-RUN reset aborts the operation: no done, and outputs go to reset values.

## Timing

- start sampled high at edge E: busy = 1 from E to E+STEPS.
- Digit i (0-based) is processed at edge E+1+i. The last digit is at E+STEPS, which also registers result, cOut, and overflow and asserts done.
- done is high for exactly the cycle between E+STEPS and E+STEPS+1; busy = 0 in that cycle.
- Latency is STEPS cycles from start edge to done. DIGIT == WIDTH gives one cycle.
- Back-to-back: start held or asserted during the DONE cycle begins the next op at E+STEPS+1, so throughput is one op per STEPS+1 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan

- WIDTH=8, DIGIT=1, add a=0x3C, b=0x19, cIn=0 → result 0x55, cOut 0, overflow 0. busy high 8 cycles; done pulses once, exactly 8 edges after start.
- Add edge cases:
  - 0x7F+0x01 → 0x80, cOut 0, overflow 1.
  - 0xFF+0x01 → 0x00, cOut 1, overflow 0.
  - 0xFF+0xFF with cIn=1 → 0xFF, cOut 1, overflow 0.
- Sub edge cases:
  - 0x05−0x07, bIn 0 → 0xFE, cOut 1, overflow 0.
  - 0x80−0x01 → 0x7F, cOut 0, overflow 1.
  - 0x00−0x00 with cIn=1 → 0xFF, cOut 1, overflow 0.
- Handshake:
  - start pulsed mid-RUN → ignored; exactly one done.
  - start held high → done pulses every 9 cycles.
  - During RUN, result keeps the previous value.
- Reset asserted on the 4th RUN cycle → next cycle busy 0, result 0, cOut 0, overflow 0; no done ever appears for that operation.
- DIGIT = 2, 4, and 8 with the vectors above → identical results, latency 4/2/1. WIDTH=4, DIGIT=1 and 2: exhaustive over a, b, mode, cIn (1024 ops) against a behavioural model.
